// File: rtl/eth_arp_tx.sv
// rtl/eth_arp_tx.sv - ARP transmitter: who-has requests, replies to requests, target MAC resolution
//
// Builds 11-word ARP frames (2 leading zero bytes, no FCS, no pad) on a 32-bit
// valid/ready stream. It answers ARP requests aimed at us and sends who-has
// requests for i_target_ip on demand or on a retry timer until that IP resolves.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_self_mac/i_self_ip  own addresses
//   i_target_ip         IPv4 address to resolve
//   i_arp_operation     rx event (01 request to us, 10 reply, 00 none), one cycle
//   i_arp_target_mac/ip sender MAC/IP of the received ARP
//   i_req               pulse: send who-has for i_target_ip
//   o_data/o_vld/i_rdy  tx word stream with handshake
//   o_sop/o_eop         first/last word of frame
//   o_busy              frame in progress
//   o_target_mac/o_target_valid  resolved MAC of i_target_ip
module eth_arp_tx #(
  parameter logic [31:0] RETRY_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [31:0] i_target_ip,
  input  logic [1:0]  i_arp_operation,
  input  logic [47:0] i_arp_target_mac,
  input  logic [31:0] i_arp_target_ip,
  input  logic        i_req,
  output logic [31:0] o_data,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_busy,
  output logic [47:0] o_target_mac,
  output logic        o_target_valid
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nx;
  logic [3:0]  widx, widx_nx;
  logic        start;

  logic        rep_pend, req_pend;
  logic [47:0] rep_mac;
  logic [31:0] rep_ip;

  // Per-frame snapshot so inputs changing mid-frame cannot corrupt it
  logic        snap_reply;
  logic [47:0] snap_peer_mac, snap_self_mac;
  logic [31:0] snap_tpa, snap_self_ip;

  logic [31:0] tip_q;
  logic [31:0] timer;
  logic        target_changed, retry_fire, resolve_hit, accept;
  logic [47:0] dmac, tha;
  logic [15:0] oper;

  assign accept         = o_vld & i_rdy;
  assign target_changed = (i_target_ip != tip_q);
  assign resolve_hit    = (i_arp_operation == 2'b10) && (i_arp_target_ip == i_target_ip);
  assign retry_fire     = ~o_target_valid & ~target_changed & (timer == RETRY_CYCLES - 32'd1);

  assign dmac = snap_reply ? snap_peer_mac : 48'hFFFF_FFFF_FFFF;
  assign tha  = snap_reply ? snap_peer_mac : 48'h0;
  assign oper = snap_reply ? 16'h0002 : 16'h0001;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      widx  <= 4'd0;
    end else begin
      state <= state_nx;
      widx  <= widx_nx;
    end
  end

  // A frame starts from IDLE, or directly after an accepted eop when more
  // work is pending so back-to-back frames leave no idle gap.
  always_comb begin
    state_nx = state;
    widx_nx  = widx;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (rep_pend | req_pend) begin
          state_nx = SEND;
          widx_nx  = 4'd0;
          start    = 1'b1;
        end
      end
      SEND: begin
        if (accept) begin
          if (widx == 4'd10) begin
            widx_nx = 4'd0;
            if (rep_pend | req_pend) begin
              start = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            widx_nx = widx + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_vld  = (state == SEND);
    o_busy = (state == SEND);
    o_sop  = (state == SEND) && (widx == 4'd0);
    o_eop  = (state == SEND) && (widx == 4'd10);
    o_data = 32'h0;
    if (state == SEND) begin
      case (widx)
        4'd0:    o_data = {16'h0000, dmac[47:32]};
        4'd1:    o_data = dmac[31:0];
        4'd2:    o_data = snap_self_mac[47:16];
        4'd3:    o_data = {snap_self_mac[15:0], 16'h0806};
        4'd4:    o_data = 32'h0001_0800;
        4'd5:    o_data = {8'h06, 8'h04, oper};
        4'd6:    o_data = snap_self_mac[47:16];
        4'd7:    o_data = {snap_self_mac[15:0], snap_self_ip[31:16]};
        4'd8:    o_data = {snap_self_ip[15:0], tha[47:32]};
        4'd9:    o_data = tha[31:0];
        4'd10:   o_data = snap_tpa;
        default: o_data = 32'h0;
      endcase
    end
  end

  // Pending flags: reply wins; a set in the same cycle as a clear re-arms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_pend      <= 1'b0;
      req_pend      <= 1'b0;
      rep_mac       <= 48'h0;
      rep_ip        <= 32'h0;
      snap_reply    <= 1'b0;
      snap_peer_mac <= 48'h0;
      snap_self_mac <= 48'h0;
      snap_tpa      <= 32'h0;
      snap_self_ip  <= 32'h0;
    end else begin
      rep_pend <= (rep_pend & ~(start & rep_pend)) | (i_arp_operation == 2'b01);
      req_pend <= (req_pend & ~(start & ~rep_pend)) | i_req | retry_fire;
      if (i_arp_operation == 2'b01) begin
        rep_mac <= i_arp_target_mac;
        rep_ip  <= i_arp_target_ip;
      end
      if (start) begin
        snap_reply    <= rep_pend;
        snap_peer_mac <= rep_mac;
        snap_self_mac <= i_self_mac;
        snap_self_ip  <= i_self_ip;
        snap_tpa      <= rep_pend ? rep_ip : i_target_ip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tip_q          <= 32'h0;
      timer          <= 32'h0;
      o_target_mac   <= 48'h0;
      o_target_valid <= 1'b0;
    end else begin
      tip_q <= i_target_ip;
      if (target_changed || o_target_valid || retry_fire) begin
        timer <= 32'h0;
      end else begin
        timer <= timer + 32'd1;
      end
      if (resolve_hit) begin
        o_target_mac   <= i_arp_target_mac;
        o_target_valid <= 1'b1;
      end else if (target_changed) begin
        o_target_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_arp_tx.sv
// tb/tb_eth_arp_tx.sv - scoreboard testbench for eth_arp_tx
module tb_eth_arp_tx;

  localparam logic [47:0] SELF_MAC = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] SELF_IP  = 32'hC0A8_0101;
  localparam logic [31:0] TGT_IP   = 32'hC0A8_0102;
  localparam logic [47:0] TGT_MAC  = 48'h001B_2C3D_4E5F;
  localparam logic [31:0] NEW_IP   = 32'hC0A8_0163;
  localparam logic [47:0] NEW_MAC  = 48'h0050_5600_0001;
  localparam logic [47:0] SHA1     = 48'h0011_2233_4455;
  localparam logic [31:0] SPA1     = 32'hC0A8_010A;
  localparam logic [47:0] SHA2     = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] SPA2     = 32'hC0A8_0114;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] i_self_mac;
  logic [31:0] i_self_ip, i_target_ip;
  logic [1:0]  i_arp_operation;
  logic [47:0] i_arp_target_mac;
  logic [31:0] i_arp_target_ip;
  logic        i_req, i_rdy;
  logic [31:0] o_data;
  logic        o_vld, o_sop, o_eop, o_busy, o_target_valid;
  logic [47:0] o_target_mac;

  eth_arp_tx #(.RETRY_CYCLES(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
    .i_target_ip(i_target_ip), .i_arp_operation(i_arp_operation),
    .i_arp_target_mac(i_arp_target_mac), .i_arp_target_ip(i_arp_target_ip),
    .i_req(i_req), .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_sop(o_sop), .o_eop(o_eop), .o_busy(o_busy),
    .o_target_mac(o_target_mac), .o_target_valid(o_target_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected frame from the field layout of an ARP packet
  task automatic push_frame(input logic reply, input logic [47:0] peer, input logic [31:0] tpa,
                            input logic [47:0] smac, input logic [31:0] sip);
    logic [47:0] dm, th;
    logic [15:0] op;
    logic [31:0] w [0:10];
    dm = reply ? peer : 48'hFFFF_FFFF_FFFF;
    th = reply ? peer : 48'h0;
    op = reply ? 16'h0002 : 16'h0001;
    w[0]  = {16'h0000, dm[47:32]};
    w[1]  = dm[31:0];
    w[2]  = smac[47:16];
    w[3]  = {smac[15:0], 16'h0806};
    w[4]  = 32'h0001_0800;
    w[5]  = {16'h0604, op};
    w[6]  = smac[47:16];
    w[7]  = {smac[15:0], sip[31:16]};
    w[8]  = {sip[15:0], th[47:32]};
    w[9]  = th[31:0];
    w[10] = tpa;
    for (int i = 0; i < 11; i++) exp_q.push_back('{w[i], (i == 0), (i == 10)});
  endtask

  // Monitor: pops expected beats on every accepted word, checks stall stability
  logic [31:0] cap [0:10];
  int    wcnt = 0, frames_done = 0, sop_cyc = 0, eop_cyc = 0, sop_gap = 0;
  int    sop_hist[$];
  logic  pv = 1'b0, pr = 1'b0;
  beat_t pb, e;

  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt = 0;
      pv   = 1'b0;
    end else begin
      if (pv && !pr && o_vld)
        chk("stall_hold", {o_data, o_sop, o_eop}, {pb.data, pb.sop, pb.eop});
      if (o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", o_data);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", {o_data, o_sop, o_eop}, {e.data, e.sop, e.eop});
        end
        if (wcnt <= 10) cap[wcnt] = o_data;
        if (o_sop) begin
          sop_gap = cyc - eop_cyc;
          sop_cyc = cyc;
          sop_hist.push_back(cyc);
        end
        wcnt++;
        if (o_eop) begin
          eop_cyc = cyc;
          wcnt    = 0;
          frames_done++;
        end
      end
      pv = o_vld;
      pr = i_rdy;
      pb = '{o_data, o_sop, o_eop};
    end
  end

  task automatic rx_event(input logic [1:0] op, input logic [47:0] mac, input logic [31:0] ip);
    @(posedge clk); #1;
    i_arp_operation  = op;
    i_arp_target_mac = mac;
    i_arp_target_ip  = ip;
    @(posedge clk); #1;
    i_arp_operation  = 2'b00;
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, frames_done, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int fd, n, k;
    rst_n = 1'b0;
    i_self_mac = SELF_MAC; i_self_ip = SELF_IP; i_target_ip = TGT_IP;
    i_arp_operation = 2'b00; i_arp_target_mac = 48'h0; i_arp_target_ip = 32'h0;
    i_req = 1'b0; i_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", o_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sop_eop", {o_sop, o_eop}, 0);
    chk("rst_tvalid", o_target_valid, 0);
    chk("rst_tmac", o_target_mac, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // resolve, then a non-matching reply
    rx_event(2'b10, TGT_MAC, TGT_IP);
    @(negedge clk);
    chk("resolve_valid", o_target_valid, 1);
    chk("resolve_mac", o_target_mac, TGT_MAC);
    rx_event(2'b10, 48'h0000_DEAD_BEEF, 32'hC0A8_01FE);
    @(negedge clk);
    chk("mismatch_valid", o_target_valid, 1);
    chk("mismatch_mac", o_target_mac, TGT_MAC);

    // reply to a request; self IP changes mid-frame must not leak in
    push_frame(1'b1, SHA1, SPA1, SELF_MAC, SELF_IP);
    rx_event(2'b01, SHA1, SPA1);
    repeat (4) @(posedge clk);
    #1 i_self_ip = 32'h0A00_0001;
    wait_frames("reply_done", 1, 40);
    i_self_ip = SELF_IP;
    chk("reply_w0", cap[0], 32'h0000_0011);
    chk("reply_w5", cap[5], 32'h0604_0002);
    chk("reply_w10", cap[10], 32'hC0A8_010A);
    chk("reply_len", eop_cyc - sop_cyc, 10);

    // request with sink toggling ready every cycle
    push_frame(1'b0, 48'h0, TGT_IP, SELF_MAC, SELF_IP);
    @(posedge clk); #1 i_req = 1'b1;
    @(posedge clk); #1 i_req = 1'b0;
    k = 0;
    while (frames_done < 2 && k < 80) begin
      @(posedge clk); #1 i_rdy = ~i_rdy;
      k++;
    end
    i_rdy = 1'b1;
    chk("toggle_done", frames_done, 2);
    chk("toggle_len", eop_cyc - sop_cyc, 20);
    chk("req_w0", cap[0], 32'h0000_FFFF);
    chk("req_w9", cap[9], 32'h0);

    // simultaneous request and reply: reply first, request right behind
    push_frame(1'b1, SHA2, SPA2, SELF_MAC, SELF_IP);
    push_frame(1'b0, 48'h0, TGT_IP, SELF_MAC, SELF_IP);
    @(posedge clk); #1;
    i_arp_operation = 2'b01; i_arp_target_mac = SHA2; i_arp_target_ip = SPA2; i_req = 1'b1;
    @(posedge clk); #1;
    i_arp_operation = 2'b00; i_req = 1'b0;
    wait_frames("both_done", 4, 60);
    chk("back_to_back_gap", sop_gap, 1);

    // target change clears resolution; retries every 100 cycles
    @(posedge clk); #1 i_target_ip = NEW_IP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("change_clears", o_target_valid, 0);
    for (int i = 0; i < 3; i++) push_frame(1'b0, 48'h0, NEW_IP, SELF_MAC, SELF_IP);
    wait_frames("retry_done", 7, 400);
    n = sop_hist.size();
    chk("retry_period_a", sop_hist[n-1] - sop_hist[n-2], 100);
    chk("retry_period_b", sop_hist[n-2] - sop_hist[n-3], 100);
    rx_event(2'b10, NEW_MAC, NEW_IP);
    @(negedge clk);
    chk("new_resolve_valid", o_target_valid, 1);
    chk("new_resolve_mac", o_target_mac, NEW_MAC);
    repeat (250) @(posedge clk);
    chk("retry_stops", frames_done, 7);

    // reset in the middle of a frame
    push_frame(1'b1, SHA1, SPA1, SELF_MAC, SELF_IP);
    rx_event(2'b01, SHA1, SPA1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(o_vld && o_data == 32'h0604_0002) && k < 40);
    chk("reached_w5", k < 40, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_vld", o_vld, 0);
    chk("abort_data", o_data, 0);
    chk("abort_sop_eop_busy", {o_sop, o_eop, o_busy}, 0);
    chk("abort_tvalid", o_target_valid, 0);
    chk("abort_tmac", o_target_mac, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fd = frames_done;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("quiet_after_reset", frames_done, fd);
    chk("idle_after_reset", o_busy, 0);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_arp_tx.md
ETH_ARP_TX -- requirements
Module: eth_arp_tx

Interface
REQ-001 SHALL have parameter RETRY_CYCLES, default 32'd50_000_000, clk cycles between ARP who-has retransmits while target unresolved.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_self_mac  in  48  own MAC.
- i_self_ip  in  32  own IPv4.
- i_target_ip  in  32  IPv4 to resolve.
- i_arp_operation  in  2  receive event: 01 request to us, 10 reply, 00 none; single-cycle, valid at rx eop.
- i_arp_target_mac  in  48  sender MAC (SHA) of received ARP.
- i_arp_target_ip  in  32  sender IP (SPA) of received ARP.
- i_req  in  1  pulse: send who-has for i_target_ip now.
- o_data  out  32  tx word.
- o_vld  out  1  o_data valid.
- i_rdy  in  1  sink ready.
- o_sop  out  1  first word of frame.
- o_eop  out  1  last word of frame.
- o_busy  out  1  frame in progress.
- o_target_mac  out  48  resolved MAC of i_target_ip.
- o_target_valid  out  1  o_target_mac valid.

Function
REQ-003 Frame SHALL be 11 words, big-endian, 2 zero bytes leading, no FCS, no pad (MAC pads): W0 {16'h0000,DMAC[47:32]}, W1 DMAC[31:0], W2 SMAC[47:16], W3 {SMAC[15:0],16'h0806}, W4 32'h0001_0800, W5 {8'h06,8'h04,OPER}, W6 i_self_mac[47:16], W7 {i_self_mac[15:0],i_self_ip[31:16]}, W8 {i_self_ip[15:0],THA[47:32]}, W9 THA[31:0], W10 TPA.
REQ-004 Reply frame: DMAC=THA=latched i_arp_target_mac, OPER=16'h0002, TPA=latched i_arp_target_ip, SMAC=i_self_mac.
REQ-005 Request frame: DMAC=48'hFFFF_FFFF_FFFF, THA=48'h0, OPER=16'h0001, TPA=i_target_ip.
REQ-006 All frame fields SHALL be snapshotted at frame start; input changes mid-frame SHALL NOT alter the frame.
REQ-007 FSM states IDLE, SEND. IDLE->SEND when a pending flag set; SEND->IDLE on W10 accepted (o_vld & i_rdy & o_eop).
REQ-008 Word index SHALL advance only on o_vld & i_rdy; o_data/o_sop/o_eop SHALL hold stable while o_vld & ~i_rdy.
REQ-009 o_vld high throughout SEND; o_sop only with W0, o_eop only with W10; o_busy = (state==SEND).
REQ-010 Reply pending SHALL set on i_arp_operation==01; MAC/IP latched into pending buffer; a second 01 while pending overwrites buffer (one deep, latest wins).
REQ-011 Request pending SHALL set on i_req or retry timer expiry; duplicates while pending are merged.
REQ-012 In IDLE with both pending, reply SHALL be sent first; the chosen flag clears on entering SEND; event arriving same cycle as clear re-sets flag.
REQ-013 Resolve: i_arp_operation==10 and i_arp_target_ip==i_target_ip SHALL capture o_target_mac and set o_target_valid next cycle; non-matching replies ignored.
REQ-014 Change of i_target_ip (registered compare) SHALL clear o_target_valid and reset retry timer to 0.
REQ-015 Retry timer SHALL count while ~o_target_valid, at RETRY_CYCLES-1 raise request pending and wrap to 0; held at 0 while o_target_valid.

Reset
REQ-016 On rst_n low: state IDLE, o_vld/o_sop/o_eop/o_busy 0, o_data 0, o_target_mac 0, o_target_valid 0, pending flags 0, timer 0, word index 0; mid-frame reset SHALL abort frame with no further words.

Verification
REQ-017 i_arp_operation=01, SHA=00:11:22:33:44:55, SPA=192.168.1.10, i_rdy=1 -> 11 consecutive words, W0=32'h0000_0011, W5=32'h0604_0002, W10=32'hC0A8_010A, sop/eop on W0/W10.
REQ-018 i_req, i_rdy toggling 1/0 each cycle -> request frame W0=32'h0000_FFFF, W9=0, 21 cycles sop-to-eop, words unchanged while stalled.
REQ-019 i_req and i_arp_operation=01 same cycle -> reply frame first, request frame immediately after (W0 of second frame the cycle after first eop accepted).
REQ-020 Reply i_arp_operation=10 matching i_target_ip -> o_target_valid=1 with captured MAC; mismatching IP -> unchanged; change i_target_ip -> o_target_valid=0.
REQ-021 RETRY_CYCLES=100, unresolved, i_rdy=1 -> request frame sop every 100 cycles; stops after matching reply.
REQ-022 rst_n asserted at W5 -> outputs zero immediately; after release, no frame until new event.
